// File: rtl/regfile_param.sv
// Multi-read-port register file with write-to-read bypass, optional zero register,
// per-entry busy scoreboard and a sequenced clear sweep.
module regfile_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       clr_req,
  output logic                       clr_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    sb_q;
  logic                idle;
  logic                wr_ok;
  logic                rsv_ok;
  logic [ADDR_W-1:0]   ra;

  assign idle   = (state_q == StIdle);
  // Entry 0 is untouchable when it is the hard-wired zero register.
  assign wr_ok  = idle && wr_en  && !(ZERO_REG && (wr_addr == '0));
  assign rsv_ok = idle && rsv_en && !(ZERO_REG && (rsv_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClr;
          idx_d   = '0;
        end
      end
      StClr: begin
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    clr_busy = (state_q == StClr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      sb_q <= '0;
    end else if (!idle) begin
      mem_q[idx_q] <= '0;
      sb_q[idx_q]  <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
        sb_q[wr_addr]  <= 1'b0;
      end
      // Later assignment wins: a new reservation supersedes the retiring write.
      if (rsv_ok) begin
        sb_q[rsv_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (ZERO_REG && (ra == '0)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end else if (BYPASS && idle && wr_en && (wr_addr == ra)) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
        rd_busy[i]                  = 1'b0;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
        rd_busy[i]                  = sb_q[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: driver pushes expected read results from a
// spec-level model, a negedge monitor pops and compares.
module tb_regfile_param;

  localparam bit ZR  = 1'b1;
  localparam bit BYP = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_addr = '0;
  logic        clr_req = 1'b0;
  logic        clr_busy;

  regfile_param #(
    .DATA_W  (16),
    .ADDR_W  (4),
    .NUM_RD  (2),
    .ZERO_REG(ZR),
    .BYPASS  (BYP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .clr_req (clr_req),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  busy;
    logic        cb;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: contents and busy bits as plain arrays, sweep as a position.
  int unsigned m_mem[16];
  bit          m_sb[16];
  bit          m_clr;
  int          m_pos;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 0;
      m_sb[i]  = 1'b0;
    end
    m_clr = 1'b0;
    m_pos = 0;
  endfunction

  function automatic logic [16:0] model_read(int a, bit wen, int wa, int wd);
    if (ZR && a == 0) return 17'h0;
    if (BYP && !m_clr && wen && wa == a) return {1'b0, 16'(wd)};
    return {m_sb[a], 16'(m_mem[a])};
  endfunction

  function automatic void model_edge(bit wen, int wa, int wd, bit ren, int rsa, bit creq);
    if (m_clr) begin
      m_mem[m_pos] = 0;
      m_sb[m_pos]  = 1'b0;
      m_pos++;
      if (m_pos == 16) begin
        m_clr = 1'b0;
        m_pos = 0;
      end
    end else begin
      if (wen && !(ZR && wa == 0)) begin
        m_mem[wa] = wd;
        m_sb[wa]  = 1'b0;
      end
      if (ren && !(ZR && rsa == 0)) m_sb[rsa] = 1'b1;
      if (creq) begin
        m_clr = 1'b1;
        m_pos = 0;
      end
    end
  endfunction

  task automatic cycle(input string tag, input bit wen, input int wa, input int wd,
                       input bit ren, input int rsa, input bit creq,
                       input int a0, input int a1, input bit rst_v);
    exp_t        e;
    logic [16:0] r0, r1;
    @(posedge clk);
    #1;
    wr_en    = wen;
    wr_addr  = 4'(wa);
    wr_data  = 16'(wd);
    rsv_en   = ren;
    rsv_addr = 4'(rsa);
    clr_req  = creq;
    rd_addr  = {4'(a1), 4'(a0)};
    if (rst_v) begin
      #1;
      rst = 1'b1;
      model_reset();
    end else begin
      rst = 1'b0;
    end
    r0     = model_read(a0, wen, wa, wd);
    r1     = model_read(a1, wen, wa, wd);
    e.data = {r1[15:0], r0[15:0]};
    e.busy = {r1[16], r0[16]};
    e.cb   = m_clr;
    e.tag  = tag;
    q.push_back(e);
    if (!rst_v) model_edge(wen, wa, wd, ren, rsa, creq);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks += 3;
      if (rd_data !== e.data) begin
        n_fail++;
        $display("FAIL %s rd_data got=%h exp=%h", e.tag, rd_data, e.data);
      end
      if (rd_busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s rd_busy got=%b exp=%b", e.tag, rd_busy, e.busy);
      end
      if (clr_busy !== e.cb) begin
        n_fail++;
        $display("FAIL %s clr_busy got=%b exp=%b", e.tag, clr_busy, e.cb);
      end
    end
  end

  initial begin
    int wait_cnt;
    model_reset();
    cycle("reset", 0, 0, 0, 0, 0, 0, 5, 9, 1);
    cycle("reset2", 0, 0, 0, 0, 0, 0, 1, 15, 1);
    // Bypass of a same-cycle write, then the stored value.
    cycle("byp_wr5", 1, 5, 16'hBEEF, 0, 0, 0, 5, 4, 0);
    cycle("rd5", 0, 0, 0, 0, 0, 0, 5, 5, 0);
    // Scoreboard set/clear and set-wins collision.
    cycle("rsv7", 0, 0, 0, 1, 7, 0, 1, 7, 0);
    cycle("busy7", 0, 0, 0, 0, 0, 0, 1, 7, 0);
    cycle("wr7_byp", 1, 7, 16'h1234, 0, 0, 0, 1, 7, 0);
    cycle("after_wr7", 0, 0, 0, 0, 0, 0, 7, 7, 0);
    cycle("rsv_wr7", 1, 7, 16'h5555, 1, 7, 0, 2, 3, 0);
    cycle("sb7_set", 0, 0, 0, 0, 0, 0, 3, 7, 0);
    // Zero register ignores writes and reservations.
    cycle("zero_wr", 1, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0);
    cycle("zero_rd", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill, then sweep with a dropped write in the middle.
    for (int i = 0; i < 16; i++) cycle("fill", 1, i, 16'h00A0 + i, 0, 0, 0, 3, i, 0);
    cycle("clr_req", 0, 0, 0, 0, 0, 1, 3, 4, 0);
    for (int i = 0; i < 18; i++)
      cycle("sweep", (i == 7), 15, 16'hDEAD, (i == 8), 9, (i == 9), 3, 15, 0);
    for (int i = 0; i < 8; i++) cycle("post_clr", 0, 0, 0, 0, 0, 0, 2 * i, 2 * i + 1, 0);
    // Reset in sweep cycle 6, then a full fresh sweep.
    for (int i = 0; i < 16; i++) cycle("fill2", 1, i, 16'h0300 + i, 1, i, 0, 10, i, 0);
    cycle("clr_req2", 0, 0, 0, 0, 0, 1, 10, 12, 0);
    for (int i = 0; i < 5; i++) cycle("sweep2", 0, 0, 0, 0, 0, 0, 1, 12, 0);
    cycle("mid_rst", 0, 0, 0, 0, 0, 0, 10, 12, 1);
    cycle("post_rst", 0, 0, 0, 0, 0, 0, 10, 12, 0);
    cycle("fill3", 1, 15, 16'h7777, 0, 0, 0, 15, 1, 0);
    cycle("clr_req3", 0, 0, 0, 0, 0, 1, 15, 1, 0);
    for (int i = 0; i < 18; i++) cycle("sweep3", 0, 0, 0, 0, 0, 0, 15, 0, 0);
    // Random traffic with occasional sweeps.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
